// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  // Per-stage control bits that travel with each partial result.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  // Number of pipeline stages (one CLA group per stage).
  function automatic int cla_stages(input int width, input int block);
    return (block > 0) ? (width / block) : 1;
  endfunction

  // True when the group width evenly tiles the operand width.
  function automatic bit cla_params_ok(input int width, input int block);
    return (block >= 1) ? ((block <= width) && ((width % block) == 0)) : 1'b0;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead group. Every internal carry is a
// flat sum of generate/propagate products, so no carry ripples bit to bit.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             p,
  output logic             g,
  output logic             co,
  output logic             c_msb_in
);

  logic [BLOCK-1:0] w_p;
  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_c;
  logic             w_grp_g;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Lookahead carries into each bit plus the group generate term.
  always_comb begin
    logic v_t;
    // NOTE: every variable written here gets a value before any branch or loop;
    // a path that leaves one unassigned would infer a latch.
    w_c     = '0;
    w_grp_g = 1'b0;
    v_t     = 1'b0;
    w_c[0]  = ci;
    for (int i = 1; i < BLOCK; i++) begin
      // Carry-in propagated through bits [i-1:0].
      v_t = ci;
      for (int m = 0; m < i; m++) v_t = v_t & w_p[m];
      w_c[i] = v_t;
      // Generate at bit j propagated through bits [i-1:j+1].
      for (int j = 0; j < i; j++) begin
        v_t = w_g[j];
        for (int m = j + 1; m < i; m++) v_t = v_t & w_p[m];
        w_c[i] = w_c[i] | v_t;
      end
    end
    for (int j = 0; j < BLOCK; j++) begin
      v_t = w_g[j];
      for (int m = j + 1; m < BLOCK; m++) v_t = v_t & w_p[m];
      w_grp_g = w_grp_g | v_t;
    end
  end

  assign s        = w_p ^ w_c;
  assign p        = &w_p;
  assign g        = w_grp_g;
  assign co       = w_grp_g | (p & ci);
  assign c_msb_in = w_c[BLOCK-1];

endmodule

// File: rtl/cla_adder_pipelined.sv
// Pipelined carry-lookahead adder: one BLOCK-bit CLA group per stage, the
// group carry registered into the next stage, unconsumed operand bits shifted
// down alongside, global stall when the registered output is not taken.
module cla_adder_pipelined
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = cla_stages(WIDTH, BLOCK);

  if (!cla_params_ok(WIDTH, BLOCK)) begin : g_param_check
    $error("cla_adder_pipelined: WIDTH=%0d is not a multiple of BLOCK=%0d", WIDTH, BLOCK);
  end

  logic w_adv;
  logic r_ovf;

  // The whole pipe moves together whenever the output slot is free or drained.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * BLOCK;
    localparam int HI_W = WIDTH - (k + 1) * BLOCK;

    logic [WIDTH-LO-1:0] w_a_src;
    logic [WIDTH-LO-1:0] w_b_src;
    logic [LO+BLOCK-1:0] w_sum_next;
    logic [BLOCK-1:0]    w_s;
    logic                w_ci;
    logic                w_vi;
    logic                w_co;
    logic                w_p;
    logic                w_g;
    logic                w_c_msb;
    logic                w_unused_pg;
    stage_ctl_t          r_ctl;
    logic [LO+BLOCK-1:0] r_sum;

    if (k == 0) begin : g_src
      assign w_a_src    = in1;
      assign w_b_src    = in2;
      assign w_ci       = cin;
      assign w_vi       = in_valid;
      assign w_sum_next = w_s;
    end else begin : g_src
      assign w_a_src    = g_stage[k-1].g_hi.r_a_hi;
      assign w_b_src    = g_stage[k-1].g_hi.r_b_hi;
      assign w_ci       = g_stage[k-1].r_ctl.carry;
      assign w_vi       = g_stage[k-1].r_ctl.valid;
      assign w_sum_next = {w_s, g_stage[k-1].r_sum};
    end

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a        (w_a_src[BLOCK-1:0]),
      .b        (w_b_src[BLOCK-1:0]),
      .ci       (w_ci),
      .s        (w_s),
      .p        (w_p),
      .g        (w_g),
      .co       (w_co),
      .c_msb_in (w_c_msb)
    );

    // Group P/G are folded into co inside the block; only the last stage's MSB carry is consumed.
    assign w_unused_pg = w_p ^ w_g ^ w_c_msb;

    // Stage control and accumulated low sum bits advance with the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every stage samples
      // its predecessor's pre-edge value; blocking here would collapse the pipe.
      if (!rst_n) begin
        r_ctl <= '0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_ctl.valid <= w_vi;
        r_ctl.carry <= w_co;
        r_sum       <= w_sum_next;
      end
    end

    if (HI_W > 0) begin : g_hi
      logic [HI_W-1:0] r_a_hi;
      logic [HI_W-1:0] r_b_hi;

      // Operand bits not yet summed shift down one group per stage.
      always_ff @(posedge clk) begin
        // NOTE: operand shift registers are not reset; the travelling valid bit
        // already marks their content meaningless until a real input arrives.
        if (w_adv) begin
          r_a_hi <= w_a_src[WIDTH-LO-1:BLOCK];
          r_b_hi <= w_b_src[WIDTH-LO-1:BLOCK];
        end
      end
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= g_stage[STAGES-1].w_c_msb ^ g_stage[STAGES-1].w_co;
    end
  end

  assign out_valid = g_stage[STAGES-1].r_ctl.valid;
  assign cout      = g_stage[STAGES-1].r_ctl.carry;
  assign sum       = g_stage[STAGES-1].r_sum;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_adder_pipelined.sv
// Self-checking bench for cla_adder_pipelined (WIDTH=32, BLOCK=8): directed
// cases followed by random traffic, scored against an arithmetic reference.
module tb_cla_adder_pipelined;

  localparam int WIDTH  = 32;
  localparam int BLOCK  = 8;
  localparam int STAGES = WIDTH / BLOCK;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in1       = '0;
  logic [WIDTH-1:0] in2       = '0;
  logic             cin       = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               acc_cyc;
  } exp_t;

  exp_t             model_q[$];
  int               checks  = 0;
  int               errors  = 0;
  int               cyc     = 0;
  bit               chk_lat = 1'b0;
  bit               stalled = 1'b0;
  logic [WIDTH-1:0] held_sum;
  logic             held_cout;
  logic             held_ovf;

  always #5 clk = ~clk;

  cla_adder_pipelined #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision addition, overflow when same-signed operands give an opposite-signed sum.
  function automatic exp_t ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    exp_t         r;
    logic [WIDTH:0] full;
    full      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    r.sum     = full[WIDTH-1:0];
    r.cout    = full[WIDTH];
    r.ovf     = (a[WIDTH-1] == b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    r.acc_cyc = 0;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return {1'b0, {(WIDTH-1){1'b1}}};
      default: return $urandom();
    endcase
  endfunction

  // One clock cycle: drive, sample mid-cycle, score any output transfer, log any input transfer.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic ordy, output bit acc);
    exp_t e;
    in_valid  = v;
    in1       = v ? a : 'x;
    in2       = v ? b : 'x;
    cin       = v ? c : 1'bx;
    out_ready = ordy;
    #1;
    check("in_ready_rule", in_ready, !out_valid || out_ready);
    if (stalled) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_sum", sum, held_sum);
      check("hold_cout", cout, held_cout);
      check("hold_ovf", ovf, held_ovf);
    end
    if (out_valid && out_ready) begin
      if (model_q.size() == 0) begin
        check("unexpected_out", out_valid, 1'b0);
      end else begin
        e = model_q.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
        check("ovf", ovf, e.ovf);
        if (chk_lat) check("latency", cyc - e.acc_cyc, STAGES);
      end
    end
    stalled   = out_valid && !out_ready;
    held_sum  = sum;
    held_cout = cout;
    held_ovf  = ovf;
    acc = in_valid && in_ready;
    if (acc) begin
      e         = ref_add(a, b, c);
      e.acc_cyc = cyc;
      model_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c, input logic ordy);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, a, b, c, ordy, acc);
      n++;
    end
    if (!acc) check("send_timeout", acc, 1'b1);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (model_q.size() != 0 && n < 200) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
      n++;
    end
    check("drain_empty", model_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Single add with latency check.
    chk_lat = 1'b1;
    send(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
    drain();

    // Back-to-back adds; fixed latency implies results on consecutive cycles.
    send(32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1);
    send(32'hD000_0000, 32'hA000_0000, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    drain();
    chk_lat = 1'b0;

    // Backpressure: fill while the output is blocked, hold, then release.
    for (int i = 0; i < 4; i++) send($urandom(), $urandom(), i[0], 1'b0);
    check("bp_full_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, acc);
      check("bp_no_accept", acc, 1'b0);
    end
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    drain();

    // Signed overflow corners.
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    drain();

    // Reset mid-operation discards everything in flight.
    for (int i = 0; i < 4; i++) send(32'h0000_0100 + i, 32'h0000_0010, 1'b0, 1'b0);
    check("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_sum", sum, '0);
    model_q.delete();
    stalled = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
      check("post_rst_idle", out_valid, 1'b0);
    end
    send(32'h0000_1234, 32'h0000_4321, 1'b1, 1'b1);
    drain();

    // Random traffic with random handshakes.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7, rand_op(), rand_op(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 7, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
